q_update: RTL and testbench

Q_UPDATE -- requirements
Module: q_update

---
 rtl/q_update_pkg.sv | 23 ++
 rtl/q_update_fx_mul_sat.sv | 24 ++
 rtl/q_update.sv | 81 ++++++++
 tb/tb_q_update.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_update_pkg.sv
// Shared constants and saturating helpers for the Q-learning update pipeline.
package q_update_pkg;

   localparam int unsigned FRAC_BITS = 16;
   localparam int unsigned Q_W       = 32;
   localparam int unsigned A_W       = 2;
   localparam int unsigned P_W       = 2 * Q_W;

   localparam logic [Q_W-1:0] Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
   localparam logic [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

   // Signed add (sub=0) or subtract (sub=1), clamped on overflow.
   function automatic logic [Q_W-1:0] sat_add(input logic [Q_W-1:0] x,
                                              input logic [Q_W-1:0] y,
                                              input logic           sub);
      logic [Q_W:0] s;
      s = sub ? ({x[Q_W-1], x} - {y[Q_W-1], y})
              : ({x[Q_W-1], x} + {y[Q_W-1], y});
      if (s[Q_W] != s[Q_W-1]) return s[Q_W] ? Q_MIN : Q_MAX;
      return s[Q_W-1:0];
   endfunction

endpackage

// File: rtl/q_update_fx_mul_sat.sv
// Fixed-point signed multiply: full-width product, floor shift by FRAC, clamp to 32 bits.
module fx_mul_sat
   import q_update_pkg::*;
#(
   parameter int unsigned FRAC = FRAC_BITS
) (
   input  logic [Q_W-1:0] a,
   input  logic [Q_W-1:0] b,
   output logic [Q_W-1:0] y
);

   logic signed [P_W-1:0] prod;
   logic signed [P_W-1:0] shifted;
   logic [P_W-Q_W:0]      upper;
   logic                  ovf;

   assign prod    = P_W'($signed(a)) * P_W'($signed(b));
   assign shifted = prod >>> FRAC;
   // Result fits only when every bit above the sign position matches it.
   assign upper   = shifted[P_W-1:Q_W-1];
   assign ovf     = !((&upper) || (~|upper));
   assign y       = ovf ? (shifted[P_W-1] ? Q_MIN : Q_MAX) : shifted[Q_W-1:0];

endmodule

// File: rtl/q_update.sv
// Four-stage Q-table update: wr_q = Q + alpha*((R + gamma*Qmax) - Q), saturating.
module q_update
   import q_update_pkg::*;
#(
   parameter int unsigned ST_W = 8,
   parameter int unsigned FRAC = FRAC_BITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_valid,
   input  logic [ST_W-1:0] s_in,
   input  logic [A_W-1:0]  a_in,
   input  logic [Q_W-1:0]  R,
   input  logic [Q_W-1:0]  Q_sa,
   input  logic [Q_W-1:0]  Qmax_next,
   input  logic [Q_W-1:0]  alpha,
   input  logic [Q_W-1:0]  gamma,
   output logic            wr_en,
   output logic [ST_W-1:0] wr_s,
   output logic [A_W-1:0]  wr_a,
   output logic [Q_W-1:0]  wr_q,
   output logic            in_hazard,
   output logic [31:0]     upd_cnt
);

   logic            s1_v, s2_v, s3_v;
   logic [ST_W-1:0] s1_s, s2_s, s3_s;
   logic [A_W-1:0]  s1_a, s2_a, s3_a;
   logic [Q_W-1:0]  s1_gq, s1_r, s1_q, s1_al;
   logic [Q_W-1:0]  s2_td, s2_q, s2_al;
   logic [Q_W-1:0]  s3_d, s3_q;
   logic [Q_W-1:0]  gq_c, td_c, d_c;

   fx_mul_sat #(.FRAC(FRAC)) u_mul_gq (.a(gamma), .b(Qmax_next), .y(gq_c));
   fx_mul_sat #(.FRAC(FRAC)) u_mul_d  (.a(s2_al), .b(s2_td),     .y(d_c));

   assign td_c = sat_add(sat_add(s1_r, s1_gq, 1'b0), s1_q, 1'b1);

   // Advisory only: flags a new input whose {s,a} is already somewhere in the pipe.
   assign in_hazard = in_valid &&
                      ((s1_v  && s1_s == s_in && s1_a == a_in) ||
                       (s2_v  && s2_s == s_in && s2_a == a_in) ||
                       (s3_v  && s3_s == s_in && s3_a == a_in) ||
                       (wr_en && wr_s == s_in && wr_a == a_in));

   // Pipeline stages; en=0 freezes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v  <= 1'b0; s1_s <= '0; s1_a <= '0;
         s1_gq <= '0;   s1_r <= '0; s1_q <= '0; s1_al <= '0;
         s2_v  <= 1'b0; s2_s <= '0; s2_a <= '0;
         s2_td <= '0;   s2_q <= '0; s2_al <= '0;
         s3_v  <= 1'b0; s3_s <= '0; s3_a <= '0;
         s3_d  <= '0;   s3_q <= '0;
         wr_en <= 1'b0; wr_s <= '0; wr_a <= '0; wr_q <= '0;
      end else if (en) begin
         s1_v  <= in_valid; s1_s <= s_in; s1_a <= a_in;
         s1_gq <= gq_c;     s1_r <= R;    s1_q <= Q_sa; s1_al <= alpha;

         s2_v  <= s1_v;  s2_s <= s1_s; s2_a <= s1_a;
         s2_td <= td_c;  s2_q <= s1_q; s2_al <= s1_al;

         s3_v  <= s2_v;  s3_s <= s2_s; s3_a <= s2_a;
         s3_d  <= d_c;   s3_q <= s2_q;

         wr_en <= s3_v;  wr_s <= s3_s; wr_a <= s3_a;
         wr_q  <= sat_add(s3_q, s3_d, 1'b0);
      end
   end

   // A write completes on an enabled edge while the stage-4 entry is valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         upd_cnt <= '0;
      end else if (en && wr_en) begin
         upd_cnt <= upd_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_q_update.sv
// Randomized and directed bench for q_update against a queue-based arithmetic model.
module tb_q_update;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  s_in = '0;
   logic [1:0]  a_in = '0;
   logic [31:0] R = '0, Q_sa = '0, Qmax_next = '0, alpha = '0, gamma = '0;
   logic        wr_en;
   logic [7:0]  wr_s;
   logic [1:0]  wr_a;
   logic [31:0] wr_q;
   logic        in_hazard;
   logic [31:0] upd_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   q_update #(.ST_W(8), .FRAC(16)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
      .s_in(s_in), .a_in(a_in), .R(R), .Q_sa(Q_sa), .Qmax_next(Qmax_next),
      .alpha(alpha), .gamma(gamma),
      .wr_en(wr_en), .wr_s(wr_s), .wr_a(wr_a), .wr_q(wr_q),
      .in_hazard(in_hazard), .upd_cnt(upd_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic longint sx(input logic [31:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [31:0] clamp(input longint v);
      if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
      return 32'(v);
   endfunction

   function automatic logic [31:0] ref_q(input logic [31:0] r, input logic [31:0] q,
                                         input logic [31:0] qm, input logic [31:0] al,
                                         input logic [31:0] ga);
      logic [31:0] gq, sum, td, d;
      gq  = clamp((sx(ga) * sx(qm)) >>> 16);
      sum = clamp(sx(r) + sx(gq));
      td  = clamp(sx(sum) - sx(q));
      d   = clamp((sx(al) * sx(td)) >>> 16);
      return clamp(sx(q) + sx(d));
   endfunction

   // ---------------- behavioural timing model ----------------
   // Each accepted input is tagged with the enabled-edge count at acceptance;
   // it is presented after three more enabled edges and retired on the fourth.
   typedef struct {
      int unsigned tag;
      logic [7:0]  s;
      logic [1:0]  a;
      logic [31:0] q;
   } ent_t;

   ent_t        mq[$];
   int unsigned ecount  = 0;
   logic [31:0] exp_cnt = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         ecount  = 0;
         exp_cnt = '0;
      end else if (en) begin
         ecount++;
         if (mq.size() > 0 && mq[0].tag + 3 < ecount) begin
            void'(mq.pop_front());
            exp_cnt = exp_cnt + 32'd1;
         end
         if (in_valid)
            mq.push_back('{tag: ecount, s: s_in, a: a_in,
                           q: ref_q(R, Q_sa, Qmax_next, alpha, gamma)});
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         logic exp_v, exp_h;
         exp_v = (mq.size() > 0) && (mq[0].tag + 3 == ecount);
         exp_h = 1'b0;
         foreach (mq[i]) if (mq[i].s == s_in && mq[i].a == a_in) exp_h = 1'b1;
         exp_h = exp_h && in_valid;
         check("wr_en", 32'(wr_en), 32'(exp_v));
         if (exp_v) begin
            check("wr_s", 32'(wr_s), 32'(mq[0].s));
            check("wr_a", 32'(wr_a), 32'(mq[0].a));
            check("wr_q", wr_q, mq[0].q);
         end
         check("upd_cnt", upd_cnt, exp_cnt);
         check("in_hazard", 32'(in_hazard), 32'(exp_h));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic v, input logic e, input logic [7:0] s, input logic [1:0] a,
                         input logic [31:0] r, input logic [31:0] q, input logic [31:0] qm,
                         input logic [31:0] al, input logic [31:0] ga);
      in_valid = v; en = e; s_in = s; a_in = a;
      R = r; Q_sa = q; Qmax_next = qm; alpha = al; gamma = ga;
   endtask

   task automatic drive(input logic v, input logic e, input logic [7:0] s, input logic [1:0] a,
                        input logic [31:0] r, input logic [31:0] q, input logic [31:0] qm,
                        input logic [31:0] al, input logic [31:0] ga);
      @(posedge clk);
      #1;
      set_in(v, e, s, a, r, q, qm, al, ga);
   endtask

   task automatic idle(input logic e);
      drive(1'b0, e, 8'd0, 2'd0, '0, '0, '0, '0, '0);
   endtask

   // Asserts reset between edges, checks the cleared outputs, releases right after an edge.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      set_in(1'b0, 1'b1, 8'd0, 2'd0, '0, '0, '0, '0, '0);
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_q", wr_q, 32'd0);
      check("rst_wr_sa", 32'({wr_s, wr_a}), 32'd0);
      check("rst_upd_cnt", upd_cnt, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Steps idle cycles until wr_en is seen; returns how many cycles that took.
   task automatic wait_wr(input int exp_lat, input string nm);
      int n;
      for (n = 1; n <= 12; n++) begin
         idle(1'b1);
         @(negedge clk);
         if (wr_en) break;
      end
      check(nm, 32'(n), 32'(exp_lat));
   endtask

   function automatic logic [31:0] rnd_word();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
   endfunction

   function automatic logic [31:0] rnd_coef();
      if ($urandom_range(0, 7) == 0) return $urandom;
      return 32'($urandom_range(0, 32'h0001_0000));
   endfunction

   logic [31:0] vr[3]  = '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF};
   logic [31:0] vq[3]  = '{32'h0000_0000, 32'h0002_0000, 32'h7000_0000};
   logic [31:0] vqm[3] = '{32'h0000_0000, 32'h0002_0000, 32'h7FFF_FFFF};
   logic [31:0] val[3] = '{32'h0000_8000, 32'h0000_4000, 32'h0001_0000};
   logic [31:0] vga[3] = '{32'h0000_8000, 32'h0000_8000, 32'h0001_0000};
   logic [31:0] vexp[3] = '{32'h0000_8000, 32'h0001_C000, 32'h7FFF_FFFF};

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Pin the reference arithmetic with hand-derived values.
      for (int i = 0; i < 3; i++)
         check($sformatf("model_vec%0d", i), ref_q(vr[i], vq[i], vqm[i], val[i], vga[i]), vexp[i]);

      // Single transactions: latency 4, exact value, counter reaches 1.
      for (int i = 0; i < 3; i++) begin
         do_reset();
         set_in(1'b1, 1'b1, 8'd7, 2'd1, vr[i], vq[i], vqm[i], val[i], vga[i]);
         wait_wr(4, $sformatf("latency_vec%0d", i));
         check($sformatf("wr_q_vec%0d", i), wr_q, vexp[i]);
         idle(1'b1);
         @(negedge clk);
         check($sformatf("cnt_vec%0d", i), upd_cnt, 32'd1);
      end

      // Three back-to-back inputs with a two-cycle en gap.
      do_reset();
      set_in(1'b1, 1'b1, 8'd1, 2'd0, vr[0], vq[0], vqm[0], val[0], vga[0]);
      drive(1'b1, 1'b1, 8'd2, 2'd1, vr[1], vq[1], vqm[1], val[1], vga[1]);
      drive(1'b1, 1'b1, 8'd3, 2'd2, vr[2], vq[2], vqm[2], val[2], vga[2]);
      idle(1'b0);
      idle(1'b0);
      wait_wr(2, "stall_latency");
      check("stall_q0", wr_q, vexp[0]);
      for (int i = 1; i < 3; i++) begin
         idle(1'b1);
         @(negedge clk);
         check($sformatf("stall_en%0d", i), 32'(wr_en), 32'd1);
         check($sformatf("stall_q%0d", i), wr_q, vexp[i]);
      end
      idle(1'b1);
      @(negedge clk);
      check("stall_cnt", upd_cnt, 32'd3);

      // Hazard on repeated {s,a}.
      do_reset();
      set_in(1'b1, 1'b1, 8'd5, 2'd2, vr[0], vq[0], vqm[0], val[0], vga[0]);
      @(negedge clk);
      check("haz_first", 32'(in_hazard), 32'd0);
      drive(1'b1, 1'b1, 8'd5, 2'd2, vr[1], vq[1], vqm[1], val[1], vga[1]);
      @(negedge clk);
      check("haz_second", 32'(in_hazard), 32'd1);
      drive(1'b1, 1'b1, 8'd5, 2'd1, vr[2], vq[2], vqm[2], val[2], vga[2]);
      @(negedge clk);
      check("haz_other_a", 32'(in_hazard), 32'd0);
      repeat (6) idle(1'b1);

      // Reset with entries in flight: outputs drop at once, nothing emerges later.
      do_reset();
      set_in(1'b1, 1'b1, 8'd9, 2'd3, vr[0], vq[0], vqm[0], val[0], vga[0]);
      drive(1'b1, 1'b1, 8'd10, 2'd0, vr[1], vq[1], vqm[1], val[1], vga[1]);
      repeat (3) idle(1'b1);
      @(negedge clk);
      check("pre_rst_wr_en", 32'(wr_en), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_wr_en", 32'(wr_en), 32'd0);
      check("async_rst_wr_q", wr_q, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         idle(1'b1);
         @(negedge clk);
         check("post_rst_no_wr", 32'(wr_en), 32'd0);
      end
      check("post_rst_cnt", upd_cnt, 32'd0);

      // Randomized traffic, random en gaps and occasional resets.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 7) != 0,
               8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               rnd_word(), rnd_word(), rnd_word(), rnd_coef(), rnd_coef());
      end
      repeat (10) idle(1'b1);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
